// File: rtl/fp_operand_align_if.sv
// Handshake bundle for the mini-float operand aligner.
// Valid/ready rule for both sides: a word moves on a rising clock edge where
// valid and ready are both high; the producer holds valid and data stable until
// that edge, and ready may depend combinationally on the consumer's state.
interface fp_operand_align_if #(
    parameter int EXP_W = 3,
    parameter int MAN_W = 5
);
    localparam int W = EXP_W + MAN_W;

    // Upstream side: one operand pair per transfer
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a_in;
    logic [W-1:0]     b_in;

    // Downstream side: ordered and aligned result
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     big_out;
    logic [MAN_W-1:0] small_man_out;
    logic [EXP_W-1:0] exp_diff_out;
    logic             sticky_out;
    logic             swapped_out;

    // Environment side: supplies operands, consumes results
    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, big_out, small_man_out,
        input  exp_diff_out, sticky_out, swapped_out
    );

    // Aligner side
    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, big_out, small_man_out,
        output exp_diff_out, sticky_out, swapped_out
    );
endinterface

// File: rtl/fp_operand_align.sv
// Two-stage operand front end for the mini-float adder.
// Stage 1 orders the pair by magnitude and registers the exponent difference;
// stage 2 right-shifts the smaller mantissa into alignment and folds the
// shifted-out bits into a sticky flag. Words are {exponent, mantissa}, no sign.
module fp_operand_align #(
    parameter int EXP_W        = 3,
    parameter int MAN_W        = 5,
    parameter int TIE_MANTISSA = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    fp_operand_align_if.slave  bus
);
    localparam int W = EXP_W + MAN_W;

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic s1_adv;
    logic s2_adv;

    // A stage may load when it is empty or its contents are leaving this edge.
    assign s2_adv = !s2_valid || bus.out_ready;
    assign s1_adv = !s1_valid || s2_adv;

    // ------------------------------------------------------------------
    // Stage 1: magnitude compare and swap
    // ------------------------------------------------------------------
    logic [EXP_W-1:0] a_exp;
    logic [EXP_W-1:0] b_exp;
    logic [MAN_W-1:0] a_man;
    logic [MAN_W-1:0] b_man;
    logic             a_gt;
    logic [W-1:0]     big_sel;
    logic [W-1:0]     small_sel;
    logic [EXP_W-1:0] diff_sel;

    assign a_exp = bus.a_in[W-1:MAN_W];
    assign b_exp = bus.b_in[W-1:MAN_W];
    assign a_man = bus.a_in[MAN_W-1:0];
    assign b_man = bus.b_in[MAN_W-1:0];

    // Decide which operand leads; equal exponents fall to the mantissa only in tie mode
    always_comb begin
        a_gt = (a_exp > b_exp);
        if (TIE_MANTISSA != 0) begin
            if ((a_exp == b_exp) && (a_man >= b_man)) begin
                a_gt = 1'b1;
            end
        end
    end

    // Route the operands; the subtraction cannot wrap since big_exp >= small_exp
    always_comb begin
        big_sel   = a_gt ? bus.a_in : bus.b_in;
        small_sel = a_gt ? bus.b_in : bus.a_in;
        diff_sel  = big_sel[W-1:MAN_W] - small_sel[W-1:MAN_W];
    end

    logic [W-1:0]     s1_big;
    logic [MAN_W-1:0] s1_small_man;
    logic [EXP_W-1:0] s1_diff;
    logic             s1_swapped;

    // Stage 1 register: only the small mantissa is kept, its exponent lives in s1_diff
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_big       <= '0;
            s1_small_man <= '0;
            s1_diff      <= '0;
            s1_swapped   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_big       <= big_sel;
                s1_small_man <= small_sel[MAN_W-1:0];
                s1_diff      <= diff_sel;
                s1_swapped   <= !a_gt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: alignment shift and sticky
    // ------------------------------------------------------------------
    logic [MAN_W-1:0] shifted;
    logic             sticky;

    // Any bit position below the shift amount is lost; a shift of MAN_W or more
    // therefore clears the result and ORs the whole mantissa into sticky.
    always_comb begin
        shifted = s1_small_man >> s1_diff;
        sticky  = 1'b0;
        for (int i = 0; i < MAN_W; i++) begin
            if (i < int'(s1_diff)) begin
                sticky = sticky | s1_small_man[i];
            end
        end
    end

    logic [W-1:0]     r_big;
    logic [MAN_W-1:0] r_small_man;
    logic [EXP_W-1:0] r_diff;
    logic             r_sticky;
    logic             r_swapped;

    // Stage 2 register: holds the result until downstream takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid    <= 1'b0;
            r_big       <= '0;
            r_small_man <= '0;
            r_diff      <= '0;
            r_sticky    <= 1'b0;
            r_swapped   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                r_big       <= s1_big;
                r_small_man <= shifted;
                r_diff      <= s1_diff;
                r_sticky    <= sticky;
                r_swapped   <= s1_swapped;
            end
        end
    end

    // ------------------------------------------------------------------
    // Interface outputs
    // ------------------------------------------------------------------
    assign bus.in_ready      = s1_adv;
    assign bus.out_valid     = s2_valid;
    assign bus.big_out       = r_big;
    assign bus.small_man_out = r_small_man;
    assign bus.exp_diff_out  = r_diff;
    assign bus.sticky_out    = r_sticky;
    assign bus.swapped_out   = r_swapped;
endmodule

// File: tb/tb_fp_operand_align.sv
// Bench for fp_operand_align: two 8-bit instances (tie mode on/off) share one
// operand stream, a third instance uses a 4/8 exponent/mantissa split.
module tb_fp_operand_align;
    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic        in_valid8  = 1'b0;
    logic        out_ready8 = 1'b1;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        in_valid_w  = 1'b0;
    logic        out_ready_w = 1'b1;
    logic [11:0] aw = '0;
    logic [11:0] bw = '0;

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    logic [31:0] exp_qw[$];

    fp_operand_align_if #(.EXP_W(3), .MAN_W(5)) if0 ();
    fp_operand_align_if #(.EXP_W(3), .MAN_W(5)) if1 ();
    fp_operand_align_if #(.EXP_W(4), .MAN_W(8)) ifw ();

    assign if0.in_valid  = in_valid8;
    assign if0.a_in      = a8;
    assign if0.b_in      = b8;
    assign if0.out_ready = out_ready8;
    assign if1.in_valid  = in_valid8;
    assign if1.a_in      = a8;
    assign if1.b_in      = b8;
    assign if1.out_ready = out_ready8;
    assign ifw.in_valid  = in_valid_w;
    assign ifw.a_in      = aw;
    assign ifw.b_in      = bw;
    assign ifw.out_ready = out_ready_w;

    fp_operand_align #(.EXP_W(3), .MAN_W(5), .TIE_MANTISSA(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0));
    fp_operand_align #(.EXP_W(3), .MAN_W(5), .TIE_MANTISSA(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));
    fp_operand_align #(.EXP_W(4), .MAN_W(8), .TIE_MANTISSA(1)) u_dutw (
        .clk(clk), .rst_n(rst_n), .bus(ifw));

    // Packed observation: {big, small_man, diff, sticky, swapped}
    logic [31:0] obs0;
    logic [31:0] obs1;
    logic [31:0] obsw;
    assign obs0 = {14'd0, if0.big_out, if0.small_man_out, if0.exp_diff_out, if0.sticky_out, if0.swapped_out};
    assign obs1 = {14'd0, if1.big_out, if1.small_man_out, if1.exp_diff_out, if1.sticky_out, if1.swapped_out};
    assign obsw = {6'd0, ifw.big_out, ifw.small_man_out, ifw.exp_diff_out, ifw.sticky_out, ifw.swapped_out};

    // ---------------- reference model ----------------
    function automatic logic [31:0] model(input int ew, input int mw,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input bit tie);
        logic [31:0] mmask;
        logic [31:0] emask;
        logic [31:0] ae, be, am, bm, big, sm, diff, sman;
        bit          a_first;
        bit          st;
        mmask   = (32'd1 << mw) - 32'd1;
        emask   = (32'd1 << ew) - 32'd1;
        ae      = (a >> mw) & emask;
        be      = (b >> mw) & emask;
        am      = a & mmask;
        bm      = b & mmask;
        a_first = (ae > be) || (tie && (ae == be) && (am >= bm));
        big     = a_first ? a : b;
        sm      = a_first ? b : a;
        diff    = ((big >> mw) & emask) - ((sm >> mw) & emask);
        if (diff >= 32'(mw)) begin
            sman = 32'd0;
            st   = ((sm & mmask) != 32'd0);
        end else begin
            sman = (sm & mmask) >> diff;
            st   = ((sm & ((32'd1 << diff) - 32'd1)) != 32'd0);
        end
        return (((((((big << mw) | sman) << ew) | diff) << 1) | 32'(st)) << 1) | 32'(!a_first);
    endfunction

    // ---------------- comparison helper ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: got %h, expected %h", tag, obs, expv);
        end
    endtask

    // ---------------- scoreboards / monitors ----------------
    logic        hold_vld0 = 1'b0, hold_vld1 = 1'b0, hold_vldw = 1'b0;
    logic [31:0] hold0 = '0, hold1 = '0, holdw = '0;

    always @(negedge clk) begin
        if (!rst_n) hold_vld0 = 1'b0;
        else begin
            if (hold_vld0) chk("dut0_stall_hold", obs0, hold0);
            if (if0.out_valid && if0.out_ready) begin
                n_vec++;
                assert (exp_q0.size() != 0) else begin
                    n_err++;
                    $error("FAIL dut0_extra_result: got %h, expected no result", obs0);
                end
                if (exp_q0.size() != 0) chk("dut0_result", obs0, exp_q0.pop_front());
            end
            hold_vld0 = if0.out_valid && !if0.out_ready;
            hold0     = obs0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) hold_vld1 = 1'b0;
        else begin
            if (hold_vld1) chk("dut1_stall_hold", obs1, hold1);
            if (if1.out_valid && if1.out_ready) begin
                n_vec++;
                assert (exp_q1.size() != 0) else begin
                    n_err++;
                    $error("FAIL dut1_extra_result: got %h, expected no result", obs1);
                end
                if (exp_q1.size() != 0) chk("dut1_result", obs1, exp_q1.pop_front());
            end
            hold_vld1 = if1.out_valid && !if1.out_ready;
            hold1     = obs1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) hold_vldw = 1'b0;
        else begin
            if (hold_vldw) chk("dutw_stall_hold", obsw, holdw);
            if (ifw.out_valid && ifw.out_ready) begin
                n_vec++;
                assert (exp_qw.size() != 0) else begin
                    n_err++;
                    $error("FAIL dutw_extra_result: got %h, expected no result", obsw);
                end
                if (exp_qw.size() != 0) chk("dutw_result", obsw, exp_qw.pop_front());
            end
            hold_vldw = ifw.out_valid && !ifw.out_ready;
            holdw     = obsw;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send8(input logic [7:0] a, input logic [7:0] b);
        int budget = 40;
        a8 = a; b8 = b; in_valid8 = 1'b1;
        @(negedge clk);
        while (!if0.in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_vec++;
        assert (budget > 0) else begin
            n_err++;
            $error("FAIL send8_timeout: in_ready %0b, expected 1", if0.in_ready);
        end
        exp_q0.push_back(model(3, 5, {24'd0, a}, {24'd0, b}, 1'b1));
        exp_q1.push_back(model(3, 5, {24'd0, a}, {24'd0, b}, 1'b0));
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic send_w(input logic [11:0] a, input logic [11:0] b);
        int budget = 40;
        aw = a; bw = b; in_valid_w = 1'b1;
        @(negedge clk);
        while (!ifw.in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_vec++;
        assert (budget > 0) else begin
            n_err++;
            $error("FAIL sendw_timeout: in_ready %0b, expected 1", ifw.in_ready);
        end
        exp_qw.push_back(model(4, 8, {20'd0, a}, {20'd0, b}, 1'b1));
        @(posedge clk); #1;
        in_valid_w = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        while ((exp_q0.size() + exp_q1.size() + exp_qw.size()) != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk(tag, 32'(exp_q0.size() + exp_q1.size() + exp_qw.size()), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    time t0, t1;
    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_out_valid0", 32'(if0.out_valid), 32'd0);
        chk("rst_outputs0", obs0, 32'd0);
        chk("rst_out_validw", 32'(ifw.out_valid), 32'd0);
        chk("rst_outputsw", obsw, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready0", 32'(if0.in_ready), 32'd1);

        // Basic pair with latency from an empty pipe
        @(posedge clk); #1;
        send8(8'hB0, 8'h78);
        @(negedge clk);
        chk("lat_cycle1_valid", 32'(if0.out_valid), 32'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", 32'(if0.out_valid), 32'd1);
        chk("basic_hand_value", obs0, {14'd0, 8'hB0, 5'd6, 3'd2, 1'b0, 1'b0});
        @(posedge clk); #1;

        // Tie-break, saturation, sticky and equal-operand cases
        send8(8'h45, 8'h4A);
        send8(8'h4A, 8'h45);
        send8(8'h1F, 8'hE1);
        send8(8'h63, 8'h20);
        send8(8'h9A, 8'h9A);
        send8(8'h00, 8'h00);
        send8(8'hFF, 8'h01);
        wait_drain("directed_drain", 6);
        @(negedge clk);
        chk("tie1_equal_hand", obs0, {14'd0, 8'hFF, 5'd0, 3'd7, 1'b1, 1'b0});
        @(posedge clk); #1;

        // Backpressure: only two pairs fit while downstream is stalled
        out_ready8 = 1'b0;
        send8(8'h2C, 8'hA3);
        send8(8'hD5, 8'hD9);
        a8 = 8'h71; b8 = 8'h6E; in_valid8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", 32'(if0.in_ready), 32'd0);
            chk("bp_out_valid_high", 32'(if0.out_valid), 32'd1);
        end
        @(posedge clk); #1;
        out_ready8 = 1'b1;
        send8(8'h71, 8'h6E);
        send8(8'h08, 8'hF8);
        wait_drain("bp_drain", 8);
        @(posedge clk); #1;

        // Back-to-back random stream, one accepted per cycle
        t0 = $time;
        for (int i = 0; i < 16; i++) begin
            send8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
        t1 = $time;
        chk("stream_cycles", 32'((t1 - t0) / 10), 32'd16);
        wait_drain("stream_drain", 3);
        @(posedge clk); #1;

        // Wider format: directed corners then a random stream
        send_w({4'hF, 8'h80}, {4'h0, 8'hFF});
        send_w({4'h3, 8'h81}, {4'h1, 8'h02});
        send_w({4'h6, 8'h5A}, {4'h6, 8'h5A});
        send_w({4'h2, 8'h10}, {4'h2, 8'h11});
        for (int i = 0; i < 16; i++) begin
            send_w(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
        end
        wait_drain("wide_drain", 4);
        @(posedge clk); #1;

        // Asynchronous reset with both stages full and downstream stalled
        out_ready8 = 1'b0;
        send8(8'h3C, 8'h81);
        send8(8'h55, 8'h2A);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid0", 32'(if0.out_valid), 32'd0);
        chk("rst_mid_outputs0", obs0, 32'd0);
        chk("rst_mid_out_valid1", 32'(if1.out_valid), 32'd0);
        chk("rst_mid_outputs1", obs1, 32'd0);
        exp_q0.delete();
        exp_q1.delete();
        @(posedge clk); #1;
        out_ready8 = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_in_ready", 32'(if0.in_ready), 32'd1);
        chk("rst_release_no_stale", 32'(if0.out_valid), 32'd0);
        @(posedge clk); #1;
        send8(8'hC4, 8'h4C);
        @(negedge clk);
        chk("rst_lat_cycle1", 32'(if0.out_valid), 32'd0);
        @(negedge clk);
        chk("rst_lat_cycle2", 32'(if0.out_valid), 32'd1);
        wait_drain("final_drain", 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
